accel_port_fifo: RTL and testbench

//  Synchronous word FIFO between the shared 32-bit data bus controller and one accelerator (FFT, FIR or IIR).

---
 rtl/accel_port_fifo.sv | 152 +++++++++++++++
 tb/tb_accel_port_fifo.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_port_fifo.sv
// Registered-output word FIFO between the shared bus controller and one accelerator port.
// The optional sticky overflow/underflow flags and their clear input exist only when ACCEL_FIFO_ERR_EN is defined.
module accel_port_fifo #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_put_req,
  input  logic [DATA_W-1:0]        i_put_data,
  input  logic                     i_get_req,
  output logic [DATA_W-1:0]        o_get_data,
  output logic                     o_get_valid,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_almost_full,
  output logic                     o_almost_empty,
  output logic [$clog2(DEPTH):0]   o_count
`ifdef ACCEL_FIFO_ERR_EN
  ,
  input  logic                     i_err_clr,
  output logic                     o_ovf_err,
  output logic                     o_udf_err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_full;
  logic              r_empty;
  logic              r_almost_full;
  logic              r_almost_empty;
  logic [DATA_W-1:0] r_get_data;
  logic              r_get_valid;

  logic              w_put_acc;
  logic              w_get_acc;
  logic [CW-1:0]     w_count_nxt;

  // Accept decisions use the registered flags, so full+both favours the get and empty+both favours the put.
  assign w_put_acc = i_put_req && !r_full;
  assign w_get_acc = i_get_req && !r_empty;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_put_acc, w_get_acc})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_put_acc) begin
      r_mem[r_wr_ptr] <= i_put_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_put_acc) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_get_acc) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_nxt;
    end
  end

  // Flags are computed from the next count so they line up with r_count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
    end else begin
      r_full         <= (w_count_nxt == DEPTH_C);
      r_empty        <= (w_count_nxt == '0);
      r_almost_full  <= (w_count_nxt >= AF_C);
      r_almost_empty <= (w_count_nxt <= AE_C);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_get_data  <= '0;
      r_get_valid <= 1'b0;
    end else begin
      r_get_valid <= w_get_acc;
      if (w_get_acc) begin
        r_get_data <= r_mem[r_rd_ptr];
      end
    end
  end

`ifdef ACCEL_FIFO_ERR_EN
  logic r_ovf_err;
  logic r_udf_err;
  logic w_ovf_set;
  logic w_udf_set;

  // A get against an empty FIFO is not an underflow if the same cycle's put lands in it.
  assign w_ovf_set = i_put_req && r_full;
  assign w_udf_set = i_get_req && r_empty && !w_put_acc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ovf_err <= 1'b0;
      r_udf_err <= 1'b0;
    end else begin
      if (w_ovf_set) begin
        r_ovf_err <= 1'b1;
      end else if (i_err_clr) begin
        r_ovf_err <= 1'b0;
      end
      if (w_udf_set) begin
        r_udf_err <= 1'b1;
      end else if (i_err_clr) begin
        r_udf_err <= 1'b0;
      end
    end
  end

  assign o_ovf_err = r_ovf_err;
  assign o_udf_err = r_udf_err;
`endif

  assign o_get_data     = r_get_data;
  assign o_get_valid    = r_get_valid;
  assign o_full         = r_full;
  assign o_empty        = r_empty;
  assign o_almost_full  = r_almost_full;
  assign o_almost_empty = r_almost_empty;
  assign o_count        = r_count;

endmodule

// File: tb/tb_accel_port_fifo.sv
// Scoreboard bench for accel_port_fifo: a queue-based reference model predicts popped words and occupancy.
module tb_accel_port_fifo;
  localparam int DEPTH = 16;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;

  logic        clk;
  logic        rst_n;
  logic        put_req;
  logic [31:0] put_data;
  logic        get_req;
  logic [31:0] get_data;
  logic        get_valid;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic        almost_empty;
  logic [4:0]  count;
`ifdef ACCEL_FIFO_ERR_EN
  logic        err_clr;
  logic        ovf_err;
  logic        udf_err;
  bit          m_ovf;
  bit          m_udf;
`endif

  accel_port_fifo #(.DATA_W(32), .DEPTH(DEPTH)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_put_req      (put_req),
    .i_put_data     (put_data),
    .i_get_req      (get_req),
    .o_get_data     (get_data),
    .o_get_valid    (get_valid),
    .o_full         (full),
    .o_empty        (empty),
    .o_almost_full  (almost_full),
    .o_almost_empty (almost_empty),
    .o_count        (count)
`ifdef ACCEL_FIFO_ERR_EN
    ,
    .i_err_clr      (err_clr),
    .o_ovf_err      (ovf_err),
    .o_udf_err      (udf_err)
`endif
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] mq[$];
  logic [31:0] sb[$];
  bit          m_valid;
  int          m_n;
  bit          m_pa;
  bit          m_ga;
  logic [31:0] mon_last;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: occupancy is the queue length, accepted gets move the oldest word into the scoreboard.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      sb.delete();
      m_valid = 1'b0;
`ifdef ACCEL_FIFO_ERR_EN
      m_ovf = 1'b0;
      m_udf = 1'b0;
`endif
    end else begin
      m_n  = mq.size();
      m_pa = put_req && (m_n < DEPTH);
      m_ga = get_req && (m_n > 0);
      m_valid = m_ga;
      if (m_ga) sb.push_back(mq.pop_front());
      if (m_pa) mq.push_back(put_data);
`ifdef ACCEL_FIFO_ERR_EN
      if (put_req && m_n == DEPTH) m_ovf = 1'b1;
      else if (err_clr) m_ovf = 1'b0;
      if (get_req && m_n == 0 && !put_req) m_udf = 1'b1;
      else if (err_clr) m_udf = 1'b0;
`endif
    end
  end

  // Monitor: compares every output each cycle, popping the scoreboard whenever get_valid is seen.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("count", 32'(count), 32'(mq.size()));
      chk("full", 32'(full), 32'(mq.size() == DEPTH));
      chk("empty", 32'(empty), 32'(mq.size() == 0));
      chk("almost_full", 32'(almost_full), 32'(mq.size() >= AF));
      chk("almost_empty", 32'(almost_empty), 32'(mq.size() <= AE));
      chk("get_valid", 32'(get_valid), 32'(m_valid));
`ifdef ACCEL_FIFO_ERR_EN
      chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
      chk("udf_err", 32'(udf_err), 32'(m_udf));
`endif
      if (get_valid) begin
        if (sb.size() == 0) begin
          chk("sb_nonempty", 32'(sb.size()), 32'd1);
        end else begin
          mon_last = sb.pop_front();
          chk("get_data", get_data, mon_last);
        end
      end else begin
        chk("get_data_hold", get_data, mon_last);
      end
    end else begin
      mon_last = 32'h0;
    end
  end

  task automatic drive(input bit p, input logic [31:0] d, input bit g);
    put_req  = p;
    put_data = d;
    get_req  = g;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_aempty"}, 32'(almost_empty), 32'd1);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_afull"}, 32'(almost_full), 32'd0);
    chk({tag, "_valid"}, 32'(get_valid), 32'd0);
    chk({tag, "_data"}, get_data, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mon_last = 32'h0;
    rst_n    = 1'b0;
    put_req  = 1'b1;
    put_data = 32'hAAAA;
    get_req  = 1'b0;
`ifdef ACCEL_FIFO_ERR_EN
    err_clr  = 1'b0;
`endif
    // Reset held with put_req asserted: nothing may be written.
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("rst_hold");
    put_req = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_count", 32'(count), 32'd0);

    // Fill 1..16 then drain in order.
    for (int i = 1; i <= DEPTH; i++) begin
      drive(1'b1, 32'(i), 1'b0);
      chk("fill_count", 32'(count), 32'(i));
      chk("fill_afull", 32'(almost_full), 32'(i >= 14));
    end
    chk("fill_full", 32'(full), 32'd1);
    for (int i = 1; i <= DEPTH; i++) begin
      drive(1'b0, 32'h0, 1'b1);
      chk("drain_valid", 32'(get_valid), 32'd1);
      chk("drain_data", get_data, 32'(i));
    end
    idle();
    chk("drain_valid_off", 32'(get_valid), 32'd0);
    chk("drain_hold", get_data, 32'd16);

    // Full with both requests: get wins, 0xDEAD dropped.
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 32'h100 + 32'(i), 1'b0);
    drive(1'b1, 32'hDEAD, 1'b1);
    chk("fullboth_count", 32'(count), 32'd15);
    chk("fullboth_data", get_data, 32'h100);
    chk("fullboth_full", 32'(full), 32'd0);
`ifdef ACCEL_FIFO_ERR_EN
    chk("fullboth_ovf", 32'(ovf_err), 32'd1);
`endif
    for (int i = 1; i < DEPTH; i++) begin
      drive(1'b0, 32'h0, 1'b1);
      chk("fullboth_drain", get_data, 32'h100 + 32'(i));
    end
    idle();
`ifdef ACCEL_FIFO_ERR_EN
    err_clr = 1'b1;
    idle();
    err_clr = 1'b0;
    chk("clr_ovf", 32'(ovf_err), 32'd0);
`endif

    // Empty with both requests: put wins, no fall-through.
    drive(1'b1, 32'hBEEF, 1'b1);
    chk("emptyboth_valid", 32'(get_valid), 32'd0);
    chk("emptyboth_count", 32'(count), 32'd1);
`ifdef ACCEL_FIFO_ERR_EN
    chk("emptyboth_udf", 32'(udf_err), 32'd0);
`endif
    drive(1'b0, 32'h0, 1'b1);
    chk("emptyboth_get_valid", 32'(get_valid), 32'd1);
    chk("emptyboth_get_data", get_data, 32'hBEEF);
    idle();

    // Steady state at count 3 across pointer wrap.
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h300 + 32'(i), 1'b0);
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, $urandom, 1'b1);
      chk("wrap_count", 32'(count), 32'd3);
    end
    repeat (3) drive(1'b0, 32'h0, 1'b1);
    idle();

    // Async reset between edges at count 7 with a word just popped.
    for (int i = 0; i < 8; i++) drive(1'b1, 32'h700 + 32'(i), 1'b0);
    drive(1'b0, 32'h0, 1'b1);
    chk("pre_rst_count", 32'(count), 32'd7);
    chk("pre_rst_valid", 32'(get_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, 32'h1234, 1'b0);
    drive(1'b0, 32'h0, 1'b1);
    chk("post_rst_word", get_data, 32'h1234);
    idle();

    // Randomized traffic in phases biased towards filling, balanced, and draining.
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 600; i++) begin
`ifdef ACCEL_FIFO_ERR_EN
        err_clr = ($urandom_range(15) == 0);
`endif
        drive($urandom_range(99) < (75 - 25 * ph), $urandom,
              $urandom_range(99) < (25 + 25 * ph));
      end
    end
`ifdef ACCEL_FIFO_ERR_EN
    err_clr = 1'b0;
`endif
    for (int i = 0; i < DEPTH + 2; i++) drive(1'b0, 32'h0, 1'b1);
    idle();
    idle();
    chk("final_empty", 32'(empty), 32'd1);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
